// File: rtl/conf_sequencer.sv
// Host-side sequencer driving the NTT core controller conf/done_flag handshake.
// Optional macro SEQ_CYCLE_COUNT_EN adds the rsp_cycles run-length output.
module conf_sequencer #(
  parameter int unsigned DRAIN_CYCLES   = 14,
  parameter int unsigned TIMEOUT_CYCLES = 2047,
  parameter int unsigned CNT_W          = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  output logic [2:0] conf,
  input  logic [3:0] done_flag,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [1:0] rsp_op,
  output logic       rsp_err,
  output logic       busy
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [CNT_W-1:0] rsp_cycles
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESP} state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] DRAIN_INIT = CNT_W'(DRAIN_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       conf_q, conf_d;
  logic             cmd_ready_q, cmd_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [1:0]       rsp_op_q, rsp_op_d;
  logic             rsp_err_q, rsp_err_d;
  logic             busy_q, busy_d;
  logic [1:0]       op_q, op_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic [CNT_W-1:0] drain_cnt_q, drain_cnt_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;

  logic [3:0] exp_mask;
  logic       done_hit;
  logic       wrong_hit;
  logic       timeout_hit;

  always_comb begin
    exp_mask = '0;
    case (op_q)
      2'd1:    exp_mask = 4'b0001;
      2'd2:    exp_mask = 4'b0010;
      2'd3:    exp_mask = 4'b0100;
      default: exp_mask = '0;
    endcase
  end

  assign done_hit    = |(done_flag & exp_mask);
  assign wrong_hit   = |(done_flag & ~exp_mask);
  assign timeout_hit = (run_cnt_q >= TIMEOUT_C);

  always_comb begin
    state_d     = state_q;
    conf_d      = conf_q;
    rsp_valid_d = rsp_valid_q;
    rsp_op_d    = rsp_op_q;
    rsp_err_d   = rsp_err_q;
    op_d        = op_q;
    run_cnt_d   = run_cnt_q;
    drain_cnt_d = drain_cnt_q;
    cyc_d       = cyc_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_d  = cmd_op;
          cyc_d = '0;
          if (cmd_op != 2'd0) begin
            conf_d    = {1'b0, cmd_op};
            run_cnt_d = '0;
            rsp_err_d = 1'b0;
            state_d   = S_RUN;
          end else begin
            rsp_err_d   = 1'b1;
            rsp_op_d    = 2'd0;
            rsp_valid_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_RUN: begin
        if (run_cnt_q < TIMEOUT_C) run_cnt_d = run_cnt_q + 1'b1;
        // Expected completion wins over a stray bit, which wins over timeout.
        if (done_hit || wrong_hit || timeout_hit) begin
          conf_d      = (op_q == 2'd3) ? 3'd5 : 3'd4;
          drain_cnt_d = DRAIN_INIT;
          rsp_err_d   = !done_hit;
          cyc_d       = run_cnt_q;
          state_d     = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (drain_cnt_q == '0) begin
          conf_d      = 3'd0;
          rsp_valid_d = 1'b1;
          rsp_op_d    = op_q;
          state_d     = S_RESP;
        end else begin
          drain_cnt_d = drain_cnt_q - 1'b1;
        end
      end
      S_RESP: begin
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      conf_q      <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_op_q    <= '0;
      rsp_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      op_q        <= '0;
      run_cnt_q   <= '0;
      drain_cnt_q <= '0;
      cyc_q       <= '0;
    end else begin
      state_q     <= state_d;
      conf_q      <= conf_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_op_q    <= rsp_op_d;
      rsp_err_q   <= rsp_err_d;
      busy_q      <= busy_d;
      op_q        <= op_d;
      run_cnt_q   <= run_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      cyc_q       <= cyc_d;
    end
  end

  assign conf      = conf_q;
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = busy_q;

`ifdef SEQ_CYCLE_COUNT_EN
  assign rsp_cycles = cyc_q;
`else
  logic unused_cyc;
  assign unused_cyc = ^cyc_q;
`endif

endmodule

// File: doc/conf_sequencer.md
Name: conf_sequencer

Overview:
- Host-side initiator for the NTT core controller's conf/done_flag protocol.
- Accepts NTT/PWM/INTT commands over a valid/ready handshake and drives the 3-bit conf code into the core controller.
- Watches done_flag for the matching completion bit, then holds the DONE_NTT/DONE_INTT code while the write pipeline drains.
- Returns the controller to IDLE and posts a response with an error flag.

Parameters:
- DRAIN_CYCLES, 14: cycles conf holds the DONE_* code after completion; covers the wen delay line.
- TIMEOUT_CYCLES, 2047: maximum RUN cycles before the command is aborted with an error.
- CNT_W, 12: width of the internal run/drain counters; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept a command
- cmd_op  in  2  1=NTT, 2=PWM, 3=INTT; 0 is illegal
- conf  out  3  to controller: 0 IDLE, 1 NTT, 2 PWM, 3 INTT, 4 DONE_NTT, 5 DONE_INTT
- done_flag  in  4  from controller: bit0 NTT done, bit1 PWM done, bit2 INTT done
- rsp_valid  out  1  response pending
- rsp_ready  in  1  host accepts the response
- rsp_op  out  2  op of the completed command
- rsp_err  out  1  1 = timeout, wrong done bit, or illegal op
- busy  out  1  high in every state except S_IDLE

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-low.
- Reset values (rst==0 at a clk edge): state S_IDLE, conf=0, cmd_ready=1, rsp_valid=0, rsp_op=0, rsp_err=0, busy=0, counters=0.
- Reset mid-operation drops conf to IDLE on the same edge; the pending command is lost and no response is posted.
- All outputs are registered.
- States: S_IDLE, S_RUN, S_DRAIN, S_RESP.
- S_IDLE:
  - cmd_ready=1.
  - On cmd_valid&&cmd_ready with op in 1..3: latch op, conf<=op, run counter<=0, go S_RUN.
  - On op 0: latch op, rsp_err<=1, conf stays 0, go S_RESP directly.
- S_RUN:
  - cmd_ready=0; run counter increments each cycle.
  - done_flag is sampled only in S_RUN; it is ignored in all other states. The controller raises done_flag bit0 while conf=DONE_INTT, and that must not be seen as a completion.
  - Expected bit set (NTT bit0, PWM bit1, INTT bit2): conf<=4 for NTT/PWM or 5 for INTT; drain counter<=DRAIN_CYCLES-1; rsp_err<=0; go S_DRAIN.
  - A different nonzero done_flag bit: rsp_err<=1, take the same DONE transition.
  - Run counter reaches TIMEOUT_CYCLES without done: rsp_err<=1, take the same DONE transition.
  - Priority on the same cycle: expected bit > wrong bit > timeout.
- S_DRAIN:
  - Drain counter decrements each cycle.
  - At 0: conf<=0, rsp_valid<=1, rsp_op<=latched op, go S_RESP.
  - With DRAIN_CYCLES=14, conf holds the DONE_* code for exactly 14 cycles.
- S_RESP:
  - rsp_valid, rsp_op and rsp_err are held stable until rsp_ready.
  - On rsp_valid&&rsp_ready: rsp_valid<=0, go S_IDLE; cmd_ready is 1 on the next cycle.
  - A new command is never accepted on the same cycle a response retires.
- Nominal timing, measured from the edge where conf becomes the op code:
  - The controller registers conf one cycle later, so done_flag for NTT and INTT is high at cycle 1280 (5 stages × 256 iterations).
  - done_flag for PWM is high at cycle 256.
  - The sequencer registers done, so conf changes to DONE_* at the edge after the done cycle.
- Counters saturate and never wrap; the run counter stops at TIMEOUT_CYCLES.

Optional Feature:
- Macro SEQ_CYCLE_COUNT_EN.
- Defined:
  - Extra output rsp_cycles[CNT_W-1:0] carries the run-counter value captured at the S_RUN exit.
  - It is valid with rsp_valid and resets to 0.
  - Nominal values: NTT/INTT 1280, PWM 256.
- Undefined: the port and the capture register are absent; all other behaviour is identical.

Test Plan:
- Reset, then cmd_op=1 (NTT) with a controller model -> conf=1 for 1281 cycles, then conf=4 for 14 cycles, then 0; rsp_valid=1, rsp_op=1, rsp_err=0.
- cmd_op=3 (INTT) -> conf=5 during drain; done_flag bit0 raised by the controller during drain is ignored; rsp_err=0; rsp_cycles=1280 with SEQ_CYCLE_COUNT_EN.
- cmd_op=2 (PWM) while the model returns done_flag=4'b0001 -> conf goes to 4 the next cycle; rsp_err=1.
- Model never raises done -> after 2047 RUN cycles conf goes to 4, drains 14 cycles; rsp_err=1.
- rsp_ready held low for 50 cycles with cmd_valid=1 -> rsp fields stable, cmd_ready=0 throughout; the command is accepted only on the cycle after rsp_ready.
- rst=0 asserted at cycle 600 of an NTT run -> next edge conf=0, busy=0, rsp_valid=0; a subsequent NTT command completes normally.
